// File: rtl/reg_file_rename.sv
// =============================================================================
// Module   : reg_file_rename
// Desc     : Architectural register file with rename (busy/tag) table; absorbs
//            ROB commits and decoder issues, serves two combinational reads.
// Options  : REG_FILE_BYPASS_EN - forward a same-cycle matching commit to reads
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module reg_file_rename #(
  parameter int REG_NUM   = 32,
  parameter int REG_POS_W = 5,
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue,
  input  logic [REG_POS_W-1:0] issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 reg_write,
  input  logic [REG_POS_W-1:0] reg_rd,
  input  logic [DATA_W-1:0]    reg_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic [REG_POS_W-1:0] rs1_pos,
  output logic [DATA_W-1:0]    rs1_val,
  output logic                 rs1_busy,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  input  logic [REG_POS_W-1:0] rs2_pos,
  output logic [DATA_W-1:0]    rs2_val,
  output logic                 rs2_busy,
  output logic [ROB_POS_W-1:0] rs2_rob_pos
);

  logic [DATA_W-1:0]    r_val  [REG_NUM];
  logic [REG_NUM-1:0]   r_busy;
  logic [ROB_POS_W-1:0] r_tag  [REG_NUM];

  logic w_commit;
  logic w_issue;

  // A JALR commit arrives together with rollback, so the value write must not
  // be gated by rdy when rollback is high.
  assign w_commit = reg_write && (rdy || rollback) && (reg_rd != '0);
  assign w_issue  = issue && rdy && !rollback && (issue_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_val[i]  <= '0;
        r_busy[i] <= 1'b0;
        r_tag[i]  <= '0;
      end
    end else begin
      // Entry 0 is never written, so x0 stays zero/idle for good.
      for (int i = 1; i < REG_NUM; i++) begin
        if (w_commit && (reg_rd == REG_POS_W'(i)))
          r_val[i] <= reg_val;
        if (rollback) begin
          r_busy[i] <= 1'b0;
        end else if (w_issue && (issue_rd == REG_POS_W'(i))) begin
          r_busy[i] <= 1'b1;
          r_tag[i]  <= issue_rob_pos;
        end else if (w_commit && (reg_rd == REG_POS_W'(i)) && r_busy[i]
                     && (r_tag[i] == commit_rob_pos)) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rs1_val     = r_val[rs1_pos];
    rs1_busy    = r_busy[rs1_pos];
    rs1_rob_pos = r_tag[rs1_pos];
    if (rs1_pos == '0) begin
      rs1_val     = '0;
      rs1_busy    = 1'b0;
      rs1_rob_pos = '0;
    end
`ifdef REG_FILE_BYPASS_EN
    else if (reg_write && rdy && (reg_rd == rs1_pos) && r_busy[rs1_pos]
             && (r_tag[rs1_pos] == commit_rob_pos)) begin
      rs1_val  = reg_val;
      rs1_busy = 1'b0;
    end
`endif
  end

  always_comb begin
    rs2_val     = r_val[rs2_pos];
    rs2_busy    = r_busy[rs2_pos];
    rs2_rob_pos = r_tag[rs2_pos];
    if (rs2_pos == '0) begin
      rs2_val     = '0;
      rs2_busy    = 1'b0;
      rs2_rob_pos = '0;
    end
`ifdef REG_FILE_BYPASS_EN
    else if (reg_write && rdy && (reg_rd == rs2_pos) && r_busy[rs2_pos]
             && (r_tag[rs2_pos] == commit_rob_pos)) begin
      rs2_val  = reg_val;
      rs2_busy = 1'b0;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_rename.sv
// =============================================================================
// Module   : tb_reg_file_rename
// Desc     : Table-driven self-checking bench for reg_file_rename with a read
//            scoreboard queue; REG_FILE_BYPASS_EN selects same-cycle expectations.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_reg_file_rename;

  localparam int REG_NUM   = 32;
  localparam int REG_POS_W = 5;
  localparam int ROB_POS_W = 4;
  localparam int DATA_W    = 32;
`ifdef REG_FILE_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 rdy, rollback, issue, reg_write;
  logic [REG_POS_W-1:0] issue_rd, reg_rd, rs1_pos, rs2_pos;
  logic [ROB_POS_W-1:0] issue_rob_pos, commit_rob_pos;
  logic [DATA_W-1:0]    reg_val;
  logic [DATA_W-1:0]    rs1_val, rs2_val;
  logic                 rs1_busy, rs2_busy;
  logic [ROB_POS_W-1:0] rs1_rob_pos, rs2_rob_pos;

  always #5 clk = ~clk;

  reg_file_rename #(
    .REG_NUM(REG_NUM), .REG_POS_W(REG_POS_W), .ROB_POS_W(ROB_POS_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
    .commit_rob_pos(commit_rob_pos),
    .rs1_pos(rs1_pos), .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_rob_pos(rs1_rob_pos),
    .rs2_pos(rs2_pos), .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_rob_pos(rs2_rob_pos)
  );

  typedef struct {
    string      name;
    bit         iss;  int ird;  int itag;
    bit         wr;   int wrd;  int wval; int wtag;
    bit         rb;   bit rdy;
    int         rs1;  int e1v;  bit e1b;  int e1t;
    int         rs2;  int e2v;  bit e2b;  int e2t;
  } vec_t;

  typedef struct {
    string name;
    int    port;
    logic [DATA_W-1:0]    val;
    logic                 busy;
    logic [ROB_POS_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  function automatic vec_t mk(string n, bit iss, int ird, int itag, bit wr, int wrd,
                              int wval, int wtag, bit rb, bit r, int rs1, int e1v,
                              bit e1b, int e1t, int rs2, int e2v, bit e2b, int e2t);
    vec_t v;
    v.name = n; v.iss = iss; v.ird = ird; v.itag = itag;
    v.wr = wr; v.wrd = wrd; v.wval = wval; v.wtag = wtag; v.rb = rb; v.rdy = r;
    v.rs1 = rs1; v.e1v = e1v; v.e1b = e1b; v.e1t = e1t;
    v.rs2 = rs2; v.e2v = e2v; v.e2b = e2b; v.e2t = e2t;
    return v;
  endfunction

  task automatic chk(string n, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic push(string n, int port, int v, bit b, int t);
    exp_t e;
    e.name = n; e.port = port; e.val = DATA_W'(v); e.busy = b; e.tag = ROB_POS_W'(t);
    sb.push_back(e);
  endtask

  // Rob tag is compared only where it is defined: busy entries or x0.
  task automatic drain();
    exp_t e;
    logic [REG_POS_W-1:0] p;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      p = (e.port == 1) ? rs1_pos : rs2_pos;
      if (e.port == 1) begin
        chk({e.name, ".rs1_val"},  rs1_val, e.val);
        chk({e.name, ".rs1_busy"}, DATA_W'(rs1_busy), DATA_W'(e.busy));
        if (e.busy || p == '0) chk({e.name, ".rs1_rob"}, DATA_W'(rs1_rob_pos), DATA_W'(e.tag));
      end else begin
        chk({e.name, ".rs2_val"},  rs2_val, e.val);
        chk({e.name, ".rs2_busy"}, DATA_W'(rs2_busy), DATA_W'(e.busy));
        if (e.busy || p == '0) chk({e.name, ".rs2_rob"}, DATA_W'(rs2_rob_pos), DATA_W'(e.tag));
      end
    end
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; rollback = 1'b0; issue = 1'b0; reg_write = 1'b0;
    issue_rd = '0; issue_rob_pos = '0; reg_rd = '0; reg_val = '0; commit_rob_pos = '0;
  endtask

  initial begin
    idle_inputs();
    rs1_pos = '0; rs2_pos = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    //          name       iss rd tg  wr rd  val      tg rb rdy rs1 e1v       e1b e1t rs2 e2v       e2b e2t
    vecs.push_back(mk("rst",     0,0,0, 0,0,0,0,        0,1, 5,0,0,0,           0,0,0,0));
    vecs.push_back(mk("iss5",    1,5,3, 0,0,0,0,        0,1, 5,0,0,0,           0,0,0,0));
    vecs.push_back(mk("busy5",   0,0,0, 0,0,0,0,        0,1, 5,0,1,3,           5,0,1,3));
    vecs.push_back(mk("cmt5",    0,0,0, 1,5,'h1234,3,   0,1, 5,c_byp ? 'h1234 : 0,!c_byp,3, 0,0,0,0));
    vecs.push_back(mk("done5",   0,0,0, 0,0,0,0,        0,1, 5,'h1234,0,0,      6,0,0,0));
    vecs.push_back(mk("ren5a",   1,5,3, 0,0,0,0,        0,1, 5,'h1234,0,0,      0,0,0,0));
    vecs.push_back(mk("ren5b",   1,5,7, 0,0,0,0,        0,1, 5,'h1234,1,3,      0,0,0,0));
    vecs.push_back(mk("oldcmt",  0,0,0, 1,5,'hAA,3,     0,1, 5,'h1234,1,7,      0,0,0,0));
    vecs.push_back(mk("newer5",  0,0,0, 0,0,0,0,        0,1, 5,'hAA,1,7,        5,'hAA,1,7));
    vecs.push_back(mk("iss6",    1,6,1, 0,0,0,0,        0,1, 0,0,0,0,           6,0,0,0));
    vecs.push_back(mk("isscmt6", 1,6,2, 1,6,'h55,1,     0,1, 0,0,0,0,           6,c_byp ? 'h55 : 0,!c_byp,1));
    vecs.push_back(mk("post6",   0,0,0, 0,0,0,0,        0,1, 5,'hAA,1,7,        6,'h55,1,2));
    vecs.push_back(mk("x0wr",    1,0,4, 1,0,'hFFFF,4,   0,1, 0,0,0,0,           0,0,0,0));
    vecs.push_back(mk("x0rd",    0,0,0, 0,0,0,0,        0,1, 0,0,0,0,           0,0,0,0));
    vecs.push_back(mk("frz",     1,7,5, 1,5,'h99,7,     0,0, 7,0,0,0,           5,'hAA,1,7));
    vecs.push_back(mk("postfrz", 0,0,0, 0,0,0,0,        0,1, 7,0,0,0,           5,'hAA,1,7));
    vecs.push_back(mk("iss1",    1,1,8, 0,0,0,0,        0,1, 1,0,0,0,           0,0,0,0));
    vecs.push_back(mk("iss2",    1,2,9, 0,0,0,0,        0,1, 1,0,1,8,           0,0,0,0));
    vecs.push_back(mk("iss3",    1,3,10,0,0,0,0,        0,1, 2,0,1,9,           0,0,0,0));
    vecs.push_back(mk("rbk",     1,4,11,1,1,'h80,0,     1,0, 3,0,1,10,          1,0,1,8));
    vecs.push_back(mk("rbk_a",   0,0,0, 0,0,0,0,        0,1, 1,'h80,0,0,        4,0,0,0));
    vecs.push_back(mk("rbk_b",   0,0,0, 0,0,0,0,        0,1, 2,0,0,0,           3,0,0,0));
    vecs.push_back(mk("rbk_c",   0,0,0, 0,0,0,0,        0,1, 5,'hAA,0,0,        6,'h55,0,0));
    vecs.push_back(mk("iss9",    1,9,12,0,0,0,0,        0,1, 9,0,0,0,           0,0,0,0));
    vecs.push_back(mk("dual",    1,10,1,1,9,'h777,12,   0,1, 9,c_byp ? 'h777 : 0,!c_byp,12, 10,0,0,0));
    vecs.push_back(mk("dual_r",  0,0,0, 0,0,0,0,        0,1, 9,'h777,0,0,       10,0,1,1));

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      issue = vecs[k].iss; issue_rd = REG_POS_W'(vecs[k].ird);
      issue_rob_pos = ROB_POS_W'(vecs[k].itag);
      reg_write = vecs[k].wr; reg_rd = REG_POS_W'(vecs[k].wrd);
      reg_val = DATA_W'(vecs[k].wval); commit_rob_pos = ROB_POS_W'(vecs[k].wtag);
      rollback = vecs[k].rb; rdy = vecs[k].rdy;
      rs1_pos = REG_POS_W'(vecs[k].rs1); rs2_pos = REG_POS_W'(vecs[k].rs2);
      push(vecs[k].name, 1, vecs[k].e1v, vecs[k].e1b, vecs[k].e1t);
      push(vecs[k].name, 2, vecs[k].e2v, vecs[k].e2b, vecs[k].e2t);
      @(negedge clk);
      drain();
    end

    // Asynchronous reset mid-cycle with an issue still in flight.
    @(posedge clk);
    #1;
    idle_inputs();
    issue = 1'b1; issue_rd = 5'd5; issue_rob_pos = 4'd3;
    rs1_pos = 5'd5; rs2_pos = 5'd10;
    @(posedge clk);
    #2;
    push("prerst", 1, 'hAA, 1'b1, 3);
    push("prerst", 2, 0, 1'b1, 1);
    drain();
    #1 rst_n = 1'b0;
    #1;
    push("asyncrst", 1, 0, 1'b0, 0);
    push("asyncrst", 2, 0, 1'b0, 0);
    drain();
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    for (int r = 0; r < REG_NUM; r++) begin
      rs1_pos = REG_POS_W'(r);
      rs2_pos = REG_POS_W'(REG_NUM - 1 - r);
      #1;
      push($sformatf("clr%0d", r), 1, 0, 1'b0, 0);
      push($sformatf("clr%0d", REG_NUM - 1 - r), 2, 0, 1'b0, 0);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
